// File: rtl/key_cmd_decoder.sv
// key_cmd_decoder: PS/2 set-2 scan-code stream to one-cycle game-command pulses.
// Resolves E0/F0 prefixes, tracks held keys, drops keyboard typematic repeats,
// and generates its own auto-repeat (DAS) for left/right/soft-drop.
//
// Ports:
//   clk, rst_n      - system clock, asynchronous active-low reset
//   keycode         - scan-code byte, qualified by key_valid
//   key_valid       - one-cycle strobe per received byte
//   enable          - command gate; low forces all cmd_* to 0
//   cmd_*           - registered one-cycle command pulses
//   held            - held-key flags {pause, hard_drop, rotate, down, right, left}
module key_cmd_decoder #(
    parameter int unsigned DELAY_CYCLES = 20_000_000,
    parameter int unsigned RATE_CYCLES  = 5_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] keycode,
    input  logic       key_valid,
    input  logic       enable,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_down,
    output logic       cmd_rotate,
    output logic       cmd_hard_drop,
    output logic       cmd_pause,
    output logic [5:0] held
);

    localparam int unsigned MAXC =
        (DELAY_CYCLES > RATE_CYCLES) ? DELAY_CYCLES : RATE_CYCLES;
    localparam int CW = $clog2(MAXC);
    localparam logic [CW-1:0] DLY_LD = CW'(DELAY_CYCLES - 32'd1);
    localparam logic [CW-1:0] RATE_LD = CW'(RATE_CYCLES - 32'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_is_e0;
    logic           w_is_f0;
    logic           w_make;
    logic           w_brk;
    logic           w_ext;
    logic [5:0]     w_key;
    logic [5:0]     w_press;
    logic [5:0]     w_release;
    logic           w_new_rep;
    logic           w_own_brk;
    logic           w_expire;
    logic [2:0]     w_rep;
    logic [5:0]     w_pulse;
    logic [5:0]     r_held;
    logic [5:0]     r_cmd;
    logic [2:0]     r_owner;
    logic [CW-1:0]  r_cnt;

    assign w_is_e0 = (keycode == 8'hE0);
    assign w_is_f0 = (keycode == 8'hF0);

    // Prefix FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Prefix FSM: next state. Stray prefixes after F0 are absorbed.
    always_comb begin
        w_state_nxt = r_state;
        if (key_valid) begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_is_e0)      w_state_nxt = S_EXT;
                    else if (w_is_f0) w_state_nxt = S_BRK;
                    else              w_state_nxt = S_IDLE;
                end
                S_EXT: begin
                    if (w_is_f0)      w_state_nxt = S_EXT_BRK;
                    else if (w_is_e0) w_state_nxt = S_EXT;
                    else              w_state_nxt = S_IDLE;
                end
                S_BRK: begin
                    if (w_is_e0 || w_is_f0) w_state_nxt = S_BRK;
                    else                    w_state_nxt = S_IDLE;
                end
                S_EXT_BRK: begin
                    if (w_is_e0 || w_is_f0) w_state_nxt = S_EXT_BRK;
                    else                    w_state_nxt = S_IDLE;
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Prefix FSM: outputs (make/break/extended qualifiers for this byte)
    always_comb begin
        w_make = 1'b0;
        w_brk  = 1'b0;
        w_ext  = 1'b0;
        if (key_valid && !w_is_e0 && !w_is_f0) begin
            unique case (r_state)
                S_IDLE:    w_make = 1'b1;
                S_EXT:     begin w_make = 1'b1; w_ext = 1'b1; end
                S_BRK:     w_brk = 1'b1;
                S_EXT_BRK: begin w_brk = 1'b1; w_ext = 1'b1; end
                default:   w_make = 1'b0;
            endcase
        end
    end

    // Key map, one-hot in held[] bit order
    always_comb begin
        w_key = 6'b0;
        if (w_ext) begin
            case (keycode)
                8'h6B:   w_key = 6'b000001;
                8'h74:   w_key = 6'b000010;
                8'h72:   w_key = 6'b000100;
                8'h75:   w_key = 6'b001000;
                default: w_key = 6'b0;
            endcase
        end else begin
            case (keycode)
                8'h29:   w_key = 6'b010000;
                8'h4D:   w_key = 6'b100000;
                default: w_key = 6'b0;
            endcase
        end
    end

    // A make of an already-held key is a typematic repeat and is dropped
    assign w_press   = w_make ? (w_key & ~r_held) : 6'b0;
    assign w_release = w_brk ? w_key : 6'b0;
    assign w_new_rep = |w_press[2:0];
    assign w_own_brk = |(w_release[2:0] & r_owner);
    assign w_expire  = (|r_owner) && (r_cnt == '0);

    // New repeatable make or owner break both pre-empt an expiring repeat
    assign w_rep   = (w_expire && !w_new_rep && !w_own_brk) ? r_owner : 3'b0;
    assign w_pulse = w_press | {3'b0, w_rep};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_held <= 6'b0;
            r_cmd  <= 6'b0;
        end else begin
            r_held <= (r_held | w_press) & ~w_release;
            r_cmd  <= enable ? w_pulse : 6'b0;
        end
    end

    // Auto-repeat: shared counter keeps running with enable low,
    // so masked repeats are dropped rather than deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner <= 3'b0;
            r_cnt   <= '0;
        end else if (w_new_rep) begin
            r_owner <= w_press[2:0];
            r_cnt   <= DLY_LD;
        end else if (w_own_brk) begin
            r_owner <= 3'b0;
            r_cnt   <= '0;
        end else if (|r_owner) begin
            if (r_cnt == '0) r_cnt <= RATE_LD;
            else             r_cnt <= r_cnt - CW'(1);
        end
    end

    assign cmd_left      = r_cmd[0];
    assign cmd_right     = r_cmd[1];
    assign cmd_down      = r_cmd[2];
    assign cmd_rotate    = r_cmd[3];
    assign cmd_hard_drop = r_cmd[4];
    assign cmd_pause     = r_cmd[5];
    assign held          = r_held;

endmodule

// File: tb/tb_key_cmd_decoder.sv
// tb_key_cmd_decoder: randomized and directed bench for key_cmd_decoder
// with a cycle-time reference model of keys, holds and repeat schedule.
module tb_key_cmd_decoder;

    localparam int DLY = 10;
    localparam int RT  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] keycode = 8'h00;
    logic       key_valid = 1'b0;
    logic       enable = 1'b1;
    logic       cmd_left, cmd_right, cmd_down;
    logic       cmd_rotate, cmd_hard_drop, cmd_pause;
    logic [5:0] held;
    logic [5:0] dut_cmd;

    always #5 clk = ~clk;

    key_cmd_decoder #(
        .DELAY_CYCLES(DLY),
        .RATE_CYCLES (RT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .keycode      (keycode),
        .key_valid    (key_valid),
        .enable       (enable),
        .cmd_left     (cmd_left),
        .cmd_right    (cmd_right),
        .cmd_down     (cmd_down),
        .cmd_rotate   (cmd_rotate),
        .cmd_hard_drop(cmd_hard_drop),
        .cmd_pause    (cmd_pause),
        .held         (held)
    );

    assign dut_cmd = {cmd_pause, cmd_hard_drop, cmd_rotate,
                      cmd_down, cmd_right, cmd_left};

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Reference model: held keys, repeat owner and absolute time of next repeat
    bit         m_held[6];
    int         m_owner = -1;
    int         m_next = 0;
    bit         m_ext = 0;
    bit         m_brk = 0;
    logic [5:0] exp_cmd = 6'b0;
    logic [5:0] exp_held = 6'b0;

    int cnt[6];
    int q_left[$];
    int q_right[$];
    int q_down[$];

    function automatic int keymap(bit ext, logic [7:0] c);
        if (ext) begin
            if (c == 8'h6B) return 0;
            if (c == 8'h74) return 1;
            if (c == 8'h72) return 2;
            if (c == 8'h75) return 3;
        end else begin
            if (c == 8'h29) return 4;
            if (c == 8'h4D) return 5;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 6; i++) m_held[i] = 1'b0;
        m_owner = -1;
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_cmd = 6'b0;
        exp_held = 6'b0;
    endfunction

    // Expected outputs for the cycle after the one carrying these inputs
    function automatic void model_step(bit kv, logic [7:0] c, bit en);
        int rep;
        int k;
        logic [5:0] p;
        p = 6'b0;
        rep = (m_owner >= 0 && m_next == cyc + 1) ? m_owner : -1;
        if (kv) begin
            if (c == 8'hE0) begin
                if (!m_brk) m_ext = 1'b1;
            end else if (c == 8'hF0) begin
                m_brk = 1'b1;
            end else begin
                k = keymap(m_ext, c);
                if (k >= 0) begin
                    if (!m_brk) begin
                        if (!m_held[k]) begin
                            m_held[k] = 1'b1;
                            p[k] = 1'b1;
                            if (k < 3) begin
                                m_owner = k;
                                m_next = cyc + 1 + DLY;
                                rep = -1;
                            end
                        end
                    end else begin
                        m_held[k] = 1'b0;
                        if (k == m_owner) begin
                            m_owner = -1;
                            rep = -1;
                        end
                    end
                end
                m_ext = 1'b0;
                m_brk = 1'b0;
            end
        end
        if (rep >= 0) begin
            p[rep] = 1'b1;
            m_next = m_next + RT;
        end
        exp_cmd = en ? p : 6'b0;
        for (int i = 0; i < 6; i++) exp_held[i] = m_held[i];
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h",
                     name, cyc, act, exp);
        end
    endtask

    function automatic int total();
        int s;
        s = 0;
        for (int i = 0; i < 6; i++) s += cnt[i];
        return s;
    endfunction

    task automatic clear_logs();
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        q_left.delete();
        q_right.delete();
        q_down.delete();
    endtask

    // One clock: apply inputs, advance model, compare after the edge
    task automatic tick(bit kv, logic [7:0] c);
        key_valid = kv;
        keycode = c;
        model_step(kv, c, enable);
        @(posedge clk);
        #1;
        cyc++;
        check("cmd", {26'b0, dut_cmd}, {26'b0, exp_cmd});
        check("held", {26'b0, held}, {26'b0, exp_held});
        for (int i = 0; i < 6; i++) if (dut_cmd[i]) cnt[i]++;
        if (cmd_left)  q_left.push_back(cyc);
        if (cmd_right) q_right.push_back(cyc);
        if (cmd_down)  q_down.push_back(cyc);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    task automatic send(logic [7:0] b);
        tick(1'b1, b);
        tick(1'b0, 8'h00);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        key_valid = 1'b0;
        #1;
        check("rst_cmd", {26'b0, dut_cmd}, 32'd0);
        check("rst_held", {26'b0, held}, 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
        @(posedge clk);
        #1;
        cyc++;
        rst_n = 1'b1;
    endtask

    int m_t;
    int gap;
    int ki;
    bit brk;
    logic [7:0] code;
    bit ext;

    initial begin
        for (int i = 0; i < 6; i++) cnt[i] = 0;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Basic make and DAS schedule
        clear_logs();
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'h74);
        check("p1_right", {26'b0, dut_cmd}, 32'h02);
        check("p1_held", {26'b0, held}, 32'h02);
        tick(1'b0, 8'h00);
        check("p1_single", {26'b0, dut_cmd}, 32'h00);
        idle(19);
        check("p2_nrep", q_right.size(), 4);
        if (q_right.size() == 4) begin
            check("p2_rep1", q_right[1] - q_right[0], 10);
            check("p2_rep2", q_right[2] - q_right[0], 14);
            check("p2_rep3", q_right[3] - q_right[0], 18);
        end
        send(8'hE0);
        send(8'hF0);
        tick(1'b1, 8'h74);
        q_right.delete();
        idle(20);
        check("p2_stop", q_right.size(), 0);
        check("p2_held", {26'b0, held}, 32'h00);

        // Typematic suppression, hard drop
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 8'hE0);
            tick(1'b1, 8'h6B);
        end
        check("p3_left1", cnt[0], 1);
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h6B);
        send(8'h29);
        check("p3_hd", cnt[4], 1);
        check("p3_hdheld", {26'b0, held}, 32'h10);
        send(8'hF0);
        send(8'h29);
        check("p3_clr", {26'b0, held}, 32'h00);

        // Prefix robustness
        clear_logs();
        send(8'h6B);
        idle(3);
        check("p4_noext", total(), 0);
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'h75);
        check("p4_rot", cnt[3], 1);
        send(8'hF0);
        send(8'h1C);
        send(8'h4D);
        check("p4_pause", cnt[5], 1);
        check("p4_total", total(), 2);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        send(8'hF0);
        send(8'h4D);

        // Owner switch colliding with left expiry
        clear_logs();
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'h6B);
        idle(8);
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'h72);
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'hF0);
        tick(1'b1, 8'h6B);
        idle(16);
        check("p5_left", cnt[0], 1);
        check("p5_ndown", q_down.size(), 4);
        if (q_down.size() == 4) begin
            check("p5_d1", q_down[1] - q_down[0], 10);
            check("p5_d2", q_down[2] - q_down[0], 14);
        end
        send(8'hE0);
        send(8'hF0);
        send(8'h72);

        // Enable gating
        clear_logs();
        enable = 1'b0;
        tick(1'b1, 8'hE0);
        tick(1'b1, 8'h74);
        m_t = cyc;
        check("p6_mask", {26'b0, dut_cmd}, 32'h00);
        check("p6_held", {26'b0, held}, 32'h02);
        idle(3);
        enable = 1'b1;
        idle(8);
        check("p6_nrep", q_right.size(), 1);
        if (q_right.size() == 1) check("p6_time", q_right[0] - m_t, 10);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);

        // Reset between E0 and 74
        clear_logs();
        tick(1'b1, 8'hE0);
        do_reset();
        tick(1'b1, 8'h74);
        idle(3);
        check("p7_none", total(), 0);
        check("p7_held", {26'b0, held}, 32'h00);

        // Randomized well-formed traffic
        for (int it = 0; it < 500; it++) begin
            gap = $urandom_range(0, 14);
            idle(gap);
            enable = ($urandom_range(0, 9) != 0);
            ki = $urandom_range(0, 7);
            brk = ($urandom_range(0, 2) == 0);
            case (ki)
                0: begin ext = 1; code = 8'h6B; end
                1: begin ext = 1; code = 8'h74; end
                2: begin ext = 1; code = 8'h72; end
                3: begin ext = 1; code = 8'h75; end
                4: begin ext = 0; code = 8'h29; end
                5: begin ext = 0; code = 8'h4D; end
                6: begin ext = 0; code = 8'h1C; end
                default: begin ext = 0; code = 8'h6B; end
            endcase
            if (ext) tick(1'b1, 8'hE0);
            if (ext && $urandom_range(0, 7) == 0) tick(1'b1, 8'hE0);
            if (brk) tick(1'b1, 8'hF0);
            if ($urandom_range(0, 60) == 0) do_reset();
            tick(1'b1, code);
        end
        idle(30);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
